// File: rtl/axi_aw_w_arbiter_pkg.sv
// Shared types for the AW/W write-path arbiter and its round-robin picker.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2
  } state_e;

  typedef logic [3:0] qos_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_aw_w_arbiter_if.sv
// AW/W/B handshake bundle between the masters, the arbiter and the slave port.
// The 'slave' modport is the arbiter's view; 'master' is the surrounding fabric.
// Optional feature macro: AXI_ARB_QOS_EN adds the per-master 4-bit AW QoS field.
interface axi_aw_w_arbiter_if
  import axi_arb_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int IDX_W   = idx_width(NUM_MST)
);
  logic [NUM_MST-1:0]   mst_aw_valid;
  logic [NUM_MST-1:0]   mst_aw_ready;
  logic                 slv_aw_valid;
  logic                 slv_aw_ready;
  logic [IDX_W-1:0]     aw_sel;
  logic [NUM_MST-1:0]   mst_w_valid;
  logic [NUM_MST-1:0]   mst_w_last;
  logic [NUM_MST-1:0]   mst_w_ready;
  logic                 slv_w_valid;
  logic                 slv_w_ready;
  logic [IDX_W-1:0]     w_sel;
  logic                 slv_b_valid;
  logic                 slv_b_ready;
  logic [NUM_MST-1:0]   mst_b_valid;
  logic [NUM_MST-1:0]   mst_b_ready;
  logic [IDX_W-1:0]     b_sel;
  logic                 busy;
`ifdef AXI_ARB_QOS_EN
  logic [NUM_MST*4-1:0] mst_aw_qos;
`endif

  modport slave (
`ifdef AXI_ARB_QOS_EN
    input  mst_aw_qos,
`endif
    input  mst_aw_valid, slv_aw_ready, mst_w_valid, mst_w_last, slv_w_ready,
           slv_b_valid, mst_b_ready,
    output mst_aw_ready, slv_aw_valid, aw_sel, mst_w_ready, slv_w_valid, w_sel,
           slv_b_ready, mst_b_valid, b_sel, busy
  );

  modport master (
`ifdef AXI_ARB_QOS_EN
    output mst_aw_qos,
`endif
    output mst_aw_valid, slv_aw_ready, mst_w_valid, mst_w_last, slv_w_ready,
           slv_b_valid, mst_b_ready,
    input  mst_aw_ready, slv_aw_valid, aw_sel, mst_w_ready, slv_w_valid, w_sel,
           slv_b_ready, mst_b_valid, b_sel, busy
  );

endinterface

// File: rtl/axi_aw_w_arbiter_rr.sv
// Combinational circular priority picker, shared with the read-side arbiter.
// Optional feature macro: AXI_ARB_QOS_EN selects highest QoS, ties in circular order.
module axi_arb_rr
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_W-1:0]     ptr,
`ifdef AXI_ARB_QOS_EN
  input  logic [NUM_REQ*4-1:0] qos,
`endif
  output logic [IDX_W-1:0]     gnt,
  output logic                 found
);

`ifdef AXI_ARB_QOS_EN
  qos_t qos_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_qos
    assign qos_arr[g] = qos[g*4 +: 4];
  end
`endif

  // Walk requesters once starting at ptr; the first hit wins unless a later
  // one carries strictly higher QoS.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
`ifdef AXI_ARB_QOS_EN
    qos_t             best;
    best  = '0;
`endif
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
`ifdef AXI_ARB_QOS_EN
      if (req[idx] && (!found || qos_arr[idx] > best)) begin
        best  = qos_arr[idx];
`else
      if (req[idx] && !found) begin
`endif
        gnt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_aw_w_arbiter.sv
// Write-path arbiter for one crossbar slave port: round-robin AW grant, W routed
// from the granted master until last, B returned in AW order via a source FIFO.
// Optional feature macro: AXI_ARB_QOS_EN (QoS-first grant, round-robin tie-break).
//
// state | meaning
// IDLE  | pick next AW requester (costs one cycle), blocked while FIFO full
// AW    | present granted master's AW to the slave until accepted
// W     | route granted master's W beats until the last beat is accepted
module axi_aw_w_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int MAX_TXN = 8
) (
  input  logic               clk,
  input  logic               rst,
  axi_aw_w_arbiter_if.slave  bus
);

  localparam int IDX_W  = idx_width(NUM_MST);
  localparam int ADDR_W = $clog2(MAX_TXN);
  localparam int PTR_W  = ADDR_W + 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] fifo_q [MAX_TXN];
  logic [IDX_W-1:0] fifo_d [MAX_TXN];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

  logic [PTR_W-1:0] txn_cnt;
  logic             fifo_full, fifo_empty, push, pop;
  logic [IDX_W-1:0] head, pick_idx;
  logic             pick_found;

  assign txn_cnt    = wptr_q - rptr_q;
  assign fifo_full  = (txn_cnt == PTR_W'(MAX_TXN));
  assign fifo_empty = (txn_cnt == '0);
  assign head       = fifo_q[rptr_q[ADDR_W-1:0]];
  assign bus.busy   = (state_q != IDLE) || !fifo_empty;

  axi_arb_rr #(.NUM_REQ(NUM_MST), .IDX_W(IDX_W)) u_rr (
    .req   (bus.mst_aw_valid),
    .ptr   (rr_q),
`ifdef AXI_ARB_QOS_EN
    .qos   (bus.mst_aw_qos),
`endif
    .gnt   (pick_idx),
    .found (pick_found)
  );

  // Grant FSM: next state, grant/pointer update and AW/W routing.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    rr_d             = rr_q;
    push             = 1'b0;
    bus.slv_aw_valid = 1'b0;
    bus.aw_sel       = '0;
    bus.mst_aw_ready = '0;
    bus.slv_w_valid  = 1'b0;
    bus.w_sel        = '0;
    bus.mst_w_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          gnt_d   = pick_idx;
          state_d = AW;
        end
      end
      AW: begin
        bus.slv_aw_valid        = 1'b1;
        bus.aw_sel              = gnt_q;
        bus.mst_aw_ready[gnt_q] = bus.slv_aw_ready;
        if (bus.slv_aw_ready) begin
          push    = 1'b1;
          rr_d    = (gnt_q == IDX_W'(NUM_MST-1)) ? '0 : gnt_q + IDX_W'(1);
          state_d = W;
        end
      end
      W: begin
        bus.w_sel              = gnt_q;
        bus.slv_w_valid        = bus.mst_w_valid[gnt_q];
        bus.mst_w_ready[gnt_q] = bus.slv_w_ready;
        if (bus.mst_w_valid[gnt_q] && bus.slv_w_ready && bus.mst_w_last[gnt_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // B return path follows the FIFO head, independent of the grant FSM.
  always_comb begin
    bus.b_sel       = '0;
    bus.mst_b_valid = '0;
    bus.slv_b_ready = 1'b0;
    pop             = 1'b0;
    if (!fifo_empty) begin
      bus.b_sel             = head;
      bus.mst_b_valid[head] = bus.slv_b_valid;
      bus.slv_b_ready       = bus.mst_b_ready[head];
      pop                   = bus.slv_b_valid && bus.mst_b_ready[head];
    end
  end

  // Source-index FIFO update; pointers carry a wrap bit so full is count==depth.
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q[ADDR_W-1:0]] = gnt_q;
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
  end

  // State registers; reset drops any in-flight transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fifo_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fifo_q  <= fifo_d;
    end
  end

  // A granted master must keep AW valid until the slave accepts it.
  a_aw_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == AW) |-> bus.mst_aw_valid[gnt_q]);

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Directed bench for axi_aw_w_arbiter (NUM_MST=4, MAX_TXN=8).
module tb_axi_aw_w_arbiter;
  import axi_arb_pkg::*;

  localparam int NUM_MST = 4;
  localparam int MAX_TXN = 8;

  logic clk = 1'b0;
  logic rst;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   hs;

  axi_aw_w_arbiter_if #(.NUM_MST(NUM_MST)) bus ();

  axi_aw_w_arbiter #(.NUM_MST(NUM_MST), .MAX_TXN(MAX_TXN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] oh(input logic [1:0] m);
    return 32'd1 << m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_grant(input logic [1:0] m, input bit drop);
    int guard;
    guard = 0;
    #1;
    while (bus.slv_aw_valid !== 1'b1 && guard < 40) begin
      @(posedge clk); #2;
      guard++;
    end
    check("aw_valid", 32'(bus.slv_aw_valid), 32'd1);
    check("aw_sel", 32'(bus.aw_sel), 32'(m));
    check("aw_ready", 32'(bus.mst_aw_ready), oh(m));
    @(posedge clk); #1;
    if (drop) bus.mst_aw_valid[m] = 1'b0;
  endtask

  task automatic w_burst(input logic [1:0] m, input int beats, input bit toggle, output int nhs);
    int b;
    int guard;
    b = 0; guard = 0; nhs = 0;
    bus.mst_w_valid[m] = 1'b1;
    bus.mst_w_last[m]  = (beats == 1);
    while (b < beats && guard < 40) begin
      if (toggle) bus.slv_w_ready = ~bus.slv_w_ready;
      #1;
      check("w_sel", 32'(bus.w_sel), 32'(m));
      check("w_valid", 32'(bus.slv_w_valid), 32'd1);
      check("w_ready", 32'(bus.mst_w_ready), bus.slv_w_ready ? oh(m) : 32'd0);
      if (bus.slv_w_valid && bus.slv_w_ready) begin
        nhs++;
        b++;
      end
      @(posedge clk); #1;
      bus.mst_w_last[m] = (b == beats - 1);
      guard++;
    end
    bus.mst_w_valid[m] = 1'b0;
    bus.mst_w_last[m]  = 1'b0;
  endtask

  task automatic b_pop(input logic [1:0] m);
    bus.slv_b_valid = 1'b1;
    bus.mst_b_ready = 4'(oh(m));
    #1;
    check("b_sel", 32'(bus.b_sel), 32'(m));
    check("b_valid", 32'(bus.mst_b_valid), oh(m));
    check("b_ready", 32'(bus.slv_b_ready), 32'd1);
    @(posedge clk); #1;
    bus.slv_b_valid = 1'b0;
    bus.mst_b_ready = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.mst_aw_valid = '0;
    bus.slv_aw_ready = 1'b1;
    bus.mst_w_valid  = '0;
    bus.mst_w_last   = '0;
    bus.slv_w_ready  = 1'b1;
    bus.slv_b_valid  = 1'b0;
    bus.mst_b_ready  = '0;
`ifdef AXI_ARB_QOS_EN
    bus.mst_aw_qos   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_aw_valid", 32'(bus.slv_aw_valid), 32'd0);
    check("rst_aw_ready", 32'(bus.mst_aw_ready), 32'd0);
    check("rst_sels", 32'({bus.aw_sel, bus.w_sel, bus.b_sel}), 32'd0);
    check("rst_b_ready", 32'(bus.slv_b_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(dut.txn_cnt), 32'd0);
    @(posedge clk); #1;

    // Masters 0 and 2 together: grant 0 then 2, B returned in that order.
    bus.mst_aw_valid = 4'b0101;
    aw_grant(2'd0, 1'b1);
    w_burst(2'd0, 1, 1'b0, hs);
    aw_grant(2'd2, 1'b1);
    w_burst(2'd2, 1, 1'b0, hs);
    #1;
    check("t1_cnt", 32'(dut.txn_cnt), 32'd2);
    check("t1_busy", 32'(bus.busy), 32'd1);
    b_pop(2'd0);
    b_pop(2'd2);
    #1;
    check("t1_b_empty", 32'({bus.mst_b_valid, bus.slv_b_ready}), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // All four hold requests: strict rotation 0,1,2,3,0.
    pulse_reset();
    bus.mst_aw_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      aw_grant(2'(k % 4), 1'b0);
      if (k == 4) bus.mst_aw_valid = '0;
      w_burst(2'(k % 4), 1, 1'b0, hs);
    end
    #1;
    check("t2_cnt", 32'(dut.txn_cnt), 32'd5);

    // 4-beat burst from master 1 with toggling W ready; master 3's W stalled.
    pulse_reset();
    bus.mst_w_valid[3] = 1'b1;
    bus.mst_w_last[3]  = 1'b1;
    bus.mst_aw_valid   = 4'b0010;
    aw_grant(2'd1, 1'b1);
    w_burst(2'd1, 4, 1'b1, hs);
    check("t3_beats", 32'(hs), 32'd4);
    #1;
    check("t3_idle_w_sel", 32'(bus.w_sel), 32'd0);
    check("t3_idle_w_valid", 32'(bus.slv_w_valid), 32'd0);
    check("t3_m3_stalled", 32'(bus.mst_w_ready), 32'd0);
    bus.mst_w_valid[3] = 1'b0;
    bus.mst_w_last[3]  = 1'b0;
    bus.slv_w_ready    = 1'b1;

    // Fill the FIFO with 8 AWs and no B: the ninth waits for one B.
    pulse_reset();
    bus.mst_aw_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      aw_grant(2'(k % 4), 1'b0);
      w_burst(2'(k % 4), 1, 1'b0, hs);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_full_no_grant", 32'(bus.slv_aw_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("t4_cnt_full", 32'(dut.txn_cnt), 32'd8);
    check("t4_busy", 32'(bus.busy), 32'd1);
    b_pop(2'd0);
    #1;
    check("t4_decide_cycle", 32'(bus.slv_aw_valid), 32'd0);
    @(posedge clk); #1;
    check("t4_resume", 32'(bus.slv_aw_valid), 32'd1);
    aw_grant(2'd0, 1'b0);
    bus.mst_aw_valid = '0;
    w_burst(2'd0, 1, 1'b0, hs);
    for (int k = 1; k <= 8; k++) b_pop(2'(k % 4));
    #1;
    check("t4_drained_busy", 32'(bus.busy), 32'd0);

    // Reset in the W state with three transactions outstanding.
    pulse_reset();
    bus.mst_aw_valid = 4'b0111;
    aw_grant(2'd0, 1'b1);
    w_burst(2'd0, 1, 1'b0, hs);
    aw_grant(2'd1, 1'b1);
    w_burst(2'd1, 1, 1'b0, hs);
    aw_grant(2'd2, 1'b1);
    bus.mst_w_valid[2] = 1'b1;
    bus.slv_b_valid    = 1'b1;
    #1;
    check("t5_pre_cnt", 32'(dut.txn_cnt), 32'd3);
    check("t5_pre_w_valid", 32'(bus.slv_w_valid), 32'd1);
    check("t5_pre_b_valid", 32'(bus.mst_b_valid), 32'b0001);
    rst = 1'b1;
    #1;
    check("t5_w_zero", 32'({bus.slv_w_valid, bus.mst_w_ready, bus.w_sel}), 32'd0);
    check("t5_b_zero", 32'({bus.mst_b_valid, bus.slv_b_ready, bus.b_sel}), 32'd0);
    check("t5_aw_zero", 32'({bus.slv_aw_valid, bus.mst_aw_ready, bus.aw_sel}), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_cnt", 32'(dut.txn_cnt), 32'd0);
    rst = 1'b0;
    bus.mst_w_valid  = '0;
    bus.slv_b_valid  = 1'b0;
    bus.mst_aw_valid = 4'hF;
    @(posedge clk); #1;
    aw_grant(2'd0, 1'b0);
    bus.mst_aw_valid = '0;
    w_burst(2'd0, 1, 1'b0, hs);

`ifdef AXI_ARB_QOS_EN
    // QoS: master 3 (qos 9) beats master 0 (qos 2); equal qos falls back to rotation.
    pulse_reset();
    bus.mst_aw_qos   = {4'd9, 4'd0, 4'd0, 4'd2};
    bus.mst_aw_valid = 4'b1001;
    aw_grant(2'd3, 1'b1);
    w_burst(2'd3, 1, 1'b0, hs);
    aw_grant(2'd0, 1'b1);
    w_burst(2'd0, 1, 1'b0, hs);
    bus.mst_aw_qos   = 16'h5555;
    bus.mst_aw_valid = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      aw_grant(2'(k % 4), 1'b0);
      if (k == 4) bus.mst_aw_valid = '0;
      w_burst(2'(k % 4), 1, 1'b0, hs);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
